// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches words from a combinational-read,
// byte-addressed instruction memory and hands each one, tagged with its PC,
// to decode over a valid/ready handshake. Supports start, halt,
// backpressure stall and branch/jump redirect with flush.
//
// Handshake: out_valid/out_instr/out_pc form one registered output slot. A
// word moves to decode on every rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, the slot holds out_instr and
// out_pc stable. The slot refills from memory in the same edge it drains.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 64,
  parameter int          ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              running,
  output logic              misalign_err,
  output logic [15:0]       fetch_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Memory is a power-of-two size, so the byte address is the PC modulo it.
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic        misalign_q;
  logic [15:0] fetch_count_q;
  logic        handshake;

  assign handshake = out_valid_q && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: halt wins over everything while running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start)    state_d = S_RUN;
      S_RUN:          if (halt_req) state_d = S_HALT;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Output decode: status flags and the memory address derived from the PC.
  always_comb begin
    running   = (state_q == S_RUN);
    state_dbg = state_q;
    imem_addr = pc_q[ADDR_W-1:0] & ADDR_MASK[ADDR_W-1:0];
  end

  // PC, output slot and error flag, updated in halt > redirect > load > stall order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_pc_q    <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          out_valid_q <= 1'b0;
          if (start) pc_q <= RESET_PC;
        end
        S_RUN: begin
          if (halt_req) begin
            out_valid_q <= 1'b0;
          end else if (redirect_valid) begin
            pc_q        <= {redirect_target[31:2], 2'b00};
            out_valid_q <= 1'b0;
            if (redirect_target[1:0] != 2'b00) misalign_q <= 1'b1;
          end else if (!out_valid_q || out_ready) begin
            out_instr_q <= imem_rdata;
            out_pc_q    <= pc_q;
            out_valid_q <= 1'b1;
            pc_q        <= pc_q + 32'd4;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  // Accepted-word counter; counts on any handshake edge, including halt/redirect edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 16'h0;
    end else if (handshake && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule
